// File: rtl/fp16_pkg.sv
// fp16_pkg: shared binary16 constants, field layout and classifiers.
// Used by fp16_add and fp16_lzc.
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;

    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [15:0] POS_INF = 16'h7C00;
    localparam logic [15:0] NEG_INF = 16'hFC00;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

    function automatic logic is_nan(input fp16_t x);
        return (x.exp == 5'd31) && (x.man != '0);
    endfunction

    function automatic logic is_inf(input fp16_t x);
        return (x.exp == 5'd31) && (x.man == '0);
    endfunction

endpackage

// File: rtl/fp16_lzc.sv
// fp16_lzc: 14-bit leading-zero counter for post-add normalisation.
// Ports: i_data[13:0] in, o_count[3:0] = leading zeros (14 when i_data is 0).
module fp16_lzc
    import fp16_pkg::*;
(
    input  logic [13:0] i_data,
    output logic [3:0]  o_count
);

    logic [3:0] w_cnt;

    // Scan from LSB so the highest set bit is the last to write.
    always_comb begin
        w_cnt = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (i_data[i]) begin
                w_cnt = 4'(13 - i);
            end
        end
    end

    assign o_count = w_cnt;

endmodule

// File: rtl/fp16_add.sv
// fp16_add: IEEE 754 binary16 adder, round-to-nearest-even, full subnormals.
// Ports: clk, rst_n (async, active-low), s_axis_a/b_tvalid+tdata in,
//        m_axis_result_tvalid+tdata out. Combinational unless the macro
//        FP16_ADD_OUT_REG_EN is defined, which registers both outputs.
module fp16_add
    import fp16_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int EXP_W      = 5,
    parameter int MAN_W      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_axis_a_tvalid,
    input  logic [15:0] s_axis_a_tdata,
    input  logic        s_axis_b_tvalid,
    input  logic [15:0] s_axis_b_tdata,
    output logic        m_axis_result_tvalid,
    output logic [15:0] m_axis_result_tdata
);

    if (DATA_WIDTH != 16 || EXP_W != 5 || MAN_W != 10) begin : g_bad_cfg
        $error("fp16_add supports binary16 only");
    end

    fp16_t w_a;
    fp16_t w_b;
    fp16_t w_big;
    fp16_t w_sml;

    assign w_a = s_axis_a_tdata;
    assign w_b = s_axis_b_tdata;

    // Magnitude order by {exp, man}; ties keep A as the larger.
    logic w_a_ge;
    assign w_a_ge = s_axis_a_tdata[14:0] >= s_axis_b_tdata[14:0];
    assign w_big  = w_a_ge ? w_a : w_b;
    assign w_sml  = w_a_ge ? w_b : w_a;

    // Subnormals: effective exponent 1, hidden bit 0.
    logic [4:0]  w_eb;
    logic [4:0]  w_es;
    logic [10:0] w_mb;
    logic [10:0] w_ms;

    assign w_eb = (w_big.exp == '0) ? 5'd1 : w_big.exp;
    assign w_es = (w_sml.exp == '0) ? 5'd1 : w_sml.exp;
    assign w_mb = {(w_big.exp != '0), w_big.man};
    assign w_ms = {(w_sml.exp != '0), w_sml.man};

    // Align: 11 mantissa bits + guard/round/sticky.
    logic [4:0]  w_d;
    logic [13:0] w_sx;
    logic [13:0] w_mask;
    logic [13:0] w_sh;
    logic        w_st;
    logic [13:0] w_al;

    assign w_d    = w_eb - w_es;
    assign w_sx   = {w_ms, 3'b000};
    assign w_mask = (14'd1 << w_d[3:0]) - 14'd1;
    assign w_sh   = (w_d >= 5'd14) ? 14'd0 : (w_sx >> w_d[3:0]);
    assign w_st   = (w_d >= 5'd14) ? (|w_ms) : (|(w_sx & w_mask));
    assign w_al   = {w_sh[13:1], w_sh[0] | w_st};

    logic        w_sub;
    logic [14:0] w_sum;

    assign w_sub = w_big.sign ^ w_sml.sign;
    assign w_sum = w_sub ? ({1'b0, w_mb, 3'b000} - {1'b0, w_al})
                         : ({1'b0, w_mb, 3'b000} + {1'b0, w_al});

    logic [3:0] w_lz;

    fp16_lzc u_lzc (
        .i_data  (w_sum[13:0]),
        .o_count (w_lz)
    );

    // Left shift stops at exponent 1; a result still lacking the
    // hidden bit after that is subnormal.
    logic [4:0]  w_lim;
    logic [4:0]  w_shamt;
    logic [13:0] w_nl;
    logic [13:0] w_norm;
    logic [5:0]  w_en;
    logic [5:0]  w_ef;

    assign w_lim   = w_eb - 5'd1;
    assign w_shamt = ({1'b0, w_lz} > w_lim) ? w_lim : {1'b0, w_lz};
    assign w_nl    = w_sum[13:0] << w_shamt;
    assign w_norm  = w_sum[14] ? {w_sum[14:2], w_sum[1] | w_sum[0]} : w_nl;
    assign w_en    = w_sum[14] ? ({1'b0, w_eb} + 6'd1)
                               : ({1'b0, w_eb} - {1'b0, w_shamt});
    assign w_ef    = w_norm[13] ? w_en : 6'd0;

    // Adding the round bit to {exp, man} lets mantissa carries ripple
    // into the exponent, including subnormal -> normal.
    logic        w_up;
    logic [15:0] w_rnd;
    logic        w_ovf;

    assign w_up  = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
    assign w_rnd = {w_ef, w_norm[12:3]} + {15'd0, w_up};
    assign w_ovf = w_rnd[15:10] >= 6'd31;

    logic [15:0] w_res;

    always_comb begin
        w_res = {w_big.sign, w_rnd[14:0]};
        if (is_nan(w_a) || is_nan(w_b)) begin
            w_res = QNAN;
        end else if (is_inf(w_a) && is_inf(w_b) && w_sub) begin
            w_res = QNAN;
        end else if (is_inf(w_a)) begin
            w_res = s_axis_a_tdata;
        end else if (is_inf(w_b)) begin
            w_res = s_axis_b_tdata;
        end else if (w_sum == '0) begin
            w_res = {w_a.sign & w_b.sign, 15'd0};
        end else if (w_ovf) begin
            w_res = w_big.sign ? NEG_INF : POS_INF;
        end
    end

    logic w_vld;
    assign w_vld = s_axis_a_tvalid & s_axis_b_tvalid;

`ifdef FP16_ADD_OUT_REG_EN
    logic        r_vld;
    logic [15:0] r_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_res <= 16'd0;
        end else begin
            r_vld <= w_vld;
            r_res <= w_res;
        end
    end

    assign m_axis_result_tvalid = r_vld;
    assign m_axis_result_tdata  = r_res;
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n};

    assign m_axis_result_tvalid = w_vld;
    assign m_axis_result_tdata  = w_res;
`endif

endmodule

// File: tb/tb_fp16_add.sv
// tb_fp16_add: directed and random checks of fp16_add against an exact
// fixed-point reference with round-to-nearest-even.
module tb_fp16_add;

    logic        clk;
    logic        rst_n;
    logic        a_v;
    logic [15:0] a_d;
    logic        b_v;
    logic [15:0] b_d;
    logic        r_v;
    logic [15:0] r_d;

    int n_vec;
    int n_fail;

    fp16_add dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .s_axis_a_tvalid      (a_v),
        .s_axis_a_tdata       (a_d),
        .s_axis_b_tvalid      (b_v),
        .s_axis_b_tdata       (b_d),
        .m_axis_result_tvalid (r_v),
        .m_axis_result_tdata  (r_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value in units of 2^-24 (the subnormal ulp); exact for all finites.
    function automatic longint to_fx(input logic [15:0] h);
        longint e;
        longint m;
        e = longint'(h[14:10]);
        m = longint'(h[9:0]);
        if (e == 0) return m;
        return (1024 + m) << (e - 1);
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a,
                                            input logic [15:0] b);
        logic   an, bn, ai, bi, sg;
        longint fa, fb, s, mag, q, rem, half;
        int     k, be, sh;
        an = (a[14:10] == 5'd31) && (a[9:0] != 0);
        bn = (b[14:10] == 5'd31) && (b[9:0] != 0);
        ai = (a[14:10] == 5'd31) && (a[9:0] == 0);
        bi = (b[14:10] == 5'd31) && (b[9:0] == 0);
        if (an || bn) return 16'h7E00;
        if (ai && bi) return (a[15] == b[15]) ? a : 16'h7E00;
        if (ai) return a;
        if (bi) return b;
        fa = a[15] ? -to_fx(a) : to_fx(a);
        fb = b[15] ? -to_fx(b) : to_fx(b);
        s  = fa + fb;
        if (s == 0) return (a[15] & b[15]) ? 16'h8000 : 16'h0000;
        sg  = (s < 0);
        mag = sg ? -s : s;
        k = 0;
        for (int i = 0; i < 48; i++)
            if (((mag >> i) & 1) != 0) k = i;
        be = (k - 9 > 1) ? k - 9 : 1;
        sh = be - 1;
        q   = mag >> sh;
        rem = mag - (q << sh);
        if (sh > 0) begin
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        end
        if (q == 2048) begin
            q  = 1024;
            be = be + 1;
        end
        if (be >= 31) return sg ? 16'hFC00 : 16'h7C00;
        if (q < 1024) return {sg, 5'd0, 10'(q)};
        return {sg, 5'(be), 10'(q - 1024)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input logic va,
                       input logic vb, input logic [15:0] exp_d);
`ifdef FP16_ADD_OUT_REG_EN
        @(negedge clk);
        a_d = a; b_d = b; a_v = va; b_v = vb;
        @(posedge clk);
        #1;
`else
        a_d = a; b_d = b; a_v = va; b_v = vb;
        #1;
`endif
        n_vec++;
        assert (r_d === exp_d) else begin
            n_fail++;
            $error("FAIL %s data a=%h b=%h got %h want %h",
                   tag, a, b, r_d, exp_d);
        end
        n_vec++;
        assert (r_v === (va & vb)) else begin
            n_fail++;
            $error("FAIL %s valid got %b want %b", tag, r_v, va & vb);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev,
                           input logic [15:0] ed);
        n_vec++;
        assert (r_d === ed && r_v === ev) else begin
            n_fail++;
            $error("FAIL %s got %b/%h want %b/%h", tag, r_v, r_d, ev, ed);
        end
    endtask

    logic [15:0] ra, rb, re;
    int          nrand;

    initial begin
        n_vec = 0; n_fail = 0;
        rst_n = 1'b0;
        a_d = 16'h3C00; b_d = 16'h3C00; a_v = 1'b1; b_v = 1'b1;
        #12;
`ifdef FP16_ADD_OUT_REG_EN
        chk_out("reset", 1'b0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        nrand = 30000;
`else
        chk_out("reset_comb", 1'b1, 16'h4000);
        rst_n = 1'b1;
        nrand = 100000;
`endif
        chk("one_one",   16'h3C00, 16'h3C00, 1, 1, 16'h4000);
        chk("one_two",   16'h3C00, 16'h4000, 1, 1, 16'h4200);
        chk("vld_10",    16'h3C00, 16'h4000, 1, 0, 16'h4200);
        chk("vld_00",    16'h3C00, 16'h4000, 0, 0, 16'h4200);
        chk("cancel",    16'h3C00, 16'hBC00, 1, 1, 16'h0000);
        chk("nz_nz",     16'h8000, 16'h8000, 1, 1, 16'h8000);
        chk("pz_nz",     16'h0000, 16'h8000, 1, 1, 16'h0000);
        chk("three_m2",  16'h4200, 16'hC000, 1, 1, 16'h3C00);
        chk("tie_even",  16'h3C00, 16'h1000, 1, 1, 16'h3C00);
        chk("tie_odd",   16'h3C01, 16'h1000, 1, 1, 16'h3C02);
        chk("above_tie", 16'h3C00, 16'h1001, 1, 1, 16'h3C01);
        chk("ovf",       16'h7BFF, 16'h7BFF, 1, 1, 16'h7C00);
        chk("inf_ninf",  16'h7C00, 16'hFC00, 1, 1, 16'h7E00);
        chk("nan_in",    16'h7D00, 16'h3C00, 1, 1, 16'h7E00);
        chk("ninf_fin",  16'hFC00, 16'h4000, 1, 1, 16'hFC00);
        chk("sub_sub",   16'h0001, 16'h0001, 1, 1, 16'h0002);
        chk("sub_norm",  16'h03FF, 16'h0001, 1, 1, 16'h0400);
        chk("norm_sub",  16'h0400, 16'h8001, 1, 1, 16'h03FF);
        chk("x_zero",    16'h0123, 16'h0000, 1, 1, 16'h0123);
        chk("nx_zero",   16'hD5A7, 16'h8000, 1, 1, 16'hD5A7);
`ifdef FP16_ADD_OUT_REG_EN
        chk("reg_pre",   16'h3C00, 16'h3C00, 1, 1, 16'h4000);
        @(negedge clk);
        a_d = 16'h4000; b_d = 16'h4000;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        chk_out("rst_held", 1'b0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst",  16'h3C00, 16'h3C00, 1, 1, 16'h4000);
`endif
        for (int i = 0; i < nrand; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 4 != 0) begin
                rb[14:10] = 5'(int'(ra[14:10]) +
                               int'($urandom_range(0, 6)) - 3);
            end
            re = ref_add(ra, rb);
            chk("rand", ra, rb, 1'($urandom), 1'($urandom), re);
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_fail);
        $finish;
    end

endmodule
